// File: rtl/cpu_pkg.sv
// Shared types for the execute-stage multi-cycle multiply/divide unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_UDIV = 2'b01,
        MD_SDIV = 2'b10,
        MD_RSV  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    function automatic logic md_is_div(input muldiv_op_t op);
        return (op == MD_UDIV) || (op == MD_SDIV);
    endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Shared datapath: radix-2 shift-add multiply and restoring shift-subtract
// divide. One iteration per step_i; q_o ends as product low half or quotient.
module muldiv_dp #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         div_i,
    input  logic [N-1:0] opnd_i,
    input  logic [N-1:0] q_init_i,
    output logic [N-1:0] q_o
);
    logic [N-1:0] opnd_q, opnd_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] q_q, q_d;
    logic         div_q, div_d;
    logic [N:0]   mul_sum;
    logic [N:0]   shifted;
    logic [N:0]   diff;

    always_comb begin
        mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
        shifted = {acc_q, q_q[N-1]};
        diff    = shifted - {1'b0, opnd_q};

        opnd_d = opnd_q;
        acc_d  = acc_q;
        q_d    = q_q;
        div_d  = div_q;

        if (load_i) begin
            opnd_d = opnd_i;
            q_d    = q_init_i;
            acc_d  = '0;
            div_d  = div_i;
        end else if (step_i) begin
            if (div_q) begin
                // Remainder stays below the divisor, so bit N of diff is the borrow.
                if (!diff[N]) begin
                    acc_d = diff[N-1:0];
                    q_d   = {q_q[N-2:0], 1'b1};
                end else begin
                    acc_d = shifted[N-1:0];
                    q_d   = {q_q[N-2:0], 1'b0};
                end
            end else begin
                acc_d = mul_sum[N:1];
                q_d   = {mul_sum[0], q_q[N-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            div_q  <= 1'b0;
        end else begin
            opnd_q <= opnd_d;
            acc_q  <= acc_d;
            q_q    <= q_d;
            div_q  <= div_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/muldiv_seq.sv
// LEGv8 MUL/UDIV/SDIV sequencer: control FSM, iteration counter, pipeline
// stall and signed quotient fix-up around the shared muldiv_dp datapath.
module muldiv_seq
    import cpu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_E,
    input  logic [1:0]   op_E,
    input  logic [N-1:0] a_E,
    input  logic [N-1:0] b_E,
    input  logic         flush,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         dbz
);
    localparam int CW = $clog2(N) + 1;

    md_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         neg_q, neg_d;
    logic         zero_q, zero_d;
    logic         dbz_flag_q, dbz_flag_d;
    logic [N-1:0] res_hold_q, res_hold_d;
    logic         dbz_hold_q, dbz_hold_d;

    muldiv_op_t   op;
    logic         accept;
    logic         dp_load, dp_step;
    logic [N-1:0] a_mag, b_mag;
    logic [N-1:0] dp_opnd, dp_qinit, dp_q;
    logic [N-1:0] done_val;

    always_comb begin
        op     = muldiv_op_t'(op_E);
        a_mag  = (op == MD_SDIV && a_E[N-1]) ? -a_E : a_E;
        b_mag  = (op == MD_SDIV && b_E[N-1]) ? -b_E : b_E;
        // Multiplier goes into the shifting register; divisor into the operand register.
        dp_opnd  = (op == MD_MUL) ? a_E : b_mag;
        dp_qinit = (op == MD_MUL) ? b_E : a_mag;
        accept   = start_E && !flush && (state_q != MD_RUN);
        done_val = zero_q ? '0 : (neg_q ? -dp_q : dp_q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        zero_d     = zero_q;
        dbz_flag_d = dbz_flag_q;
        res_hold_d = res_hold_q;
        dbz_hold_d = dbz_hold_q;
        dp_load    = 1'b0;
        dp_step    = 1'b0;

        case (state_q)
            MD_RUN: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (flush)
                    state_d = MD_IDLE;
                else if (cnt_q == CW'(1))
                    state_d = MD_DONE;
            end
            MD_DONE: begin
                res_hold_d = done_val;
                dbz_hold_d = dbz_flag_q;
                state_d    = MD_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            if (op == MD_RSV) begin
                state_d    = MD_DONE;
                zero_d     = 1'b1;
                dbz_flag_d = 1'b0;
                neg_d      = 1'b0;
            end else if (md_is_div(op) && b_E == '0) begin
                state_d    = MD_DONE;
                zero_d     = 1'b1;
                dbz_flag_d = 1'b1;
                neg_d      = 1'b0;
            end else begin
                state_d    = MD_RUN;
                dp_load    = 1'b1;
                cnt_d      = CW'(N);
                zero_d     = 1'b0;
                dbz_flag_d = 1'b0;
                neg_d      = (op == MD_SDIV) && (a_E[N-1] ^ b_E[N-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            dbz_flag_q <= 1'b0;
            res_hold_q <= '0;
            dbz_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            zero_q     <= zero_d;
            dbz_flag_q <= dbz_flag_d;
            res_hold_q <= res_hold_d;
            dbz_hold_q <= dbz_hold_d;
        end
    end

    muldiv_dp #(.N(N)) u_dp (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (dp_load),
        .step_i   (dp_step),
        .div_i    (md_is_div(op)),
        .opnd_i   (dp_opnd),
        .q_init_i (dp_qinit),
        .q_o      (dp_q)
    );

    assign busy   = (state_q != MD_IDLE);
    assign done   = (state_q == MD_DONE);
    assign stall  = ((state_q == MD_IDLE) && start_E) || (state_q == MD_RUN)
                  || ((state_q == MD_DONE) && start_E);
    assign result = done ? done_val : res_hold_q;
    assign dbz    = done ? dbz_flag_q : dbz_hold_q;

endmodule
